// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int ADJ_THRESH = 5;
    localparam int ADJ_ADD    = 3;

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    // Pre-shift correction so the following left shift carries correctly into the next digit.
    always_comb begin
        if (din >= DIGIT_W'(ADJ_THRESH)) begin
            dout = din + DIGIT_W'(ADJ_ADD);
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/done handshake.
// Takes BIN_W shift cycles plus one result-registration cycle per conversion.
// Optional macro BCD_BLANK_EN adds the blank_n leading-zero suppression output.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [BIN_W-1:0]            bin_in,
    output logic                        busy,
    output logic                        done,
    output logic [DIGIT_W*DIGITS-1:0]   bcd_out,
    output logic                        overflow
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]           blank_n
`endif
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state;
    state_t             state_n;
    logic               accept;
    logic               finish;

    logic [BIN_W-1:0]   bin_r;
    logic [BIN_W-1:0]   bin_sh;
    logic [BCD_W-1:0]   bcd_r;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_sh;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_r;
    logic               ovf_bit;

    // One correction cell per digit of the working BCD register.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_add3 u_add3 (
                .din  (bcd_r[g*DIGIT_W +: DIGIT_W]),
                .dout (bcd_adj[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // Left shift of the corrected {BCD, bin} pair; the bit leaving the top digit flags overflow.
    always_comb begin
        {ovf_bit, bcd_sh, bin_sh} = {bcd_adj, bin_r, 1'b0};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and handshake outputs; a start in DONE chains straight into a new conversion.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        finish  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_n = SHIFT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Working registers: load on accept, shift while count remains, publish result on finish.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bin_r    <= '0;
            bcd_r    <= '0;
            cnt      <= '0;
            ovf_r    <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                bin_r <= bin_in;
                bcd_r <= '0;
                cnt   <= CNT_W'(BIN_W);
                ovf_r <= 1'b0;
            end else if ((state == SHIFT) && (cnt != '0)) begin
                bin_r <= bin_sh;
                bcd_r <= bcd_sh;
                cnt   <= cnt - CNT_W'(1);
                ovf_r <= ovf_r | ovf_bit;
            end
            if (finish) begin
                bcd_out  <= bcd_r;
                overflow <= ovf_r;
            end
        end
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nx;

    // A digit is lit if it or any more significant digit is non-zero; digit 0 always lit.
    always_comb begin
        blank_nx = '0;
        for (int unsigned i = 0; i < int'(DIGITS); i++) begin
            blank_nx[i] = |(bcd_r >> (i * DIGIT_W));
        end
        blank_nx[0] = 1'b1;
    end

    // Blanking mask is published alongside bcd_out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            blank_n <= '1;
        end else if (finish) begin
            blank_n <= blank_nx;
        end
    end
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: default (8,3), (10,3) and (16,5) configurations.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_start, a_busy, a_done, a_ovf;
    logic [7:0]  a_bin;
    logic [11:0] a_bcd;

    logic        c_start, c_busy, c_done, c_ovf;
    logic [9:0]  c_bin;
    logic [11:0] c_bcd;

    logic        b_start, b_busy, b_done, b_ovf;
    logic [15:0] b_bin;
    logic [19:0] b_bcd;

`ifdef BCD_BLANK_EN
    logic [2:0] a_blank;
    logic [2:0] c_blank;
    logic [4:0] b_blank;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .bin_in(a_bin),
        .busy(a_busy), .done(a_done), .bcd_out(a_bcd), .overflow(a_ovf)
`ifdef BCD_BLANK_EN
        , .blank_n(a_blank)
`endif
    );

    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .bin_in(c_bin),
        .busy(c_busy), .done(c_done), .bcd_out(c_bcd), .overflow(c_ovf)
`ifdef BCD_BLANK_EN
        , .blank_n(c_blank)
`endif
    );

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .bin_in(b_bin),
        .busy(b_busy), .done(b_done), .bcd_out(b_bcd), .overflow(b_ovf)
`ifdef BCD_BLANK_EN
        , .blank_n(b_blank)
`endif
    );

    // Reference: decimal digits of (v mod 10^d) via plain division.
    function automatic logic [19:0] ref_bcd(input int unsigned v, input int d);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < d; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int unsigned v, input int d);
        int unsigned lim;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        return v >= lim;
    endfunction

    // Digit i is lit when the displayed value reaches 10^i; digit 0 always lit.
    function automatic logic [4:0] ref_blank(input int unsigned v, input int d);
        logic [4:0] r;
        int unsigned lim, shown, p;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        shown = v % lim;
        r = '0;
        p = 1;
        for (int i = 0; i < d; i++) begin
            r[i] = (i == 0) || (shown >= p);
            p = p * 10;
        end
        return r;
    endfunction

    // Drivers: accept one value and count edges after the accept edge until done (bounded).
    task automatic run_a(input logic [7:0] v, output int lat);
        @(negedge clk);
        a_bin = v; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_bin = 8'($urandom);
        lat = 0;
        while (!a_done && lat < 40) begin @(negedge clk); lat++; end
    endtask

    task automatic run_c(input logic [9:0] v, output int lat);
        @(negedge clk);
        c_bin = v; c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0; c_bin = 10'($urandom);
        lat = 0;
        while (!c_done && lat < 40) begin @(negedge clk); lat++; end
    endtask

    task automatic run_b(input logic [15:0] v, output int lat);
        @(negedge clk);
        b_bin = v; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0; b_bin = 16'($urandom);
        lat = 0;
        while (!b_done && lat < 40) begin @(negedge clk); lat++; end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        a_start = 0; c_start = 0; b_start = 0;
        a_bin = 8'hA5; c_bin = '0; b_bin = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({a_busy, a_done, a_ovf} !== 3'b000 || a_bcd !== 12'h000) begin
            $display("FAIL reset_a busy/done/ovf=%b bcd=%h exp 000/000", {a_busy, a_done, a_ovf}, a_bcd);
            n_fail++;
        end
        n_tests++;
        if (b_busy !== 1'b0 || b_bcd !== 20'h0 || c_bcd !== 12'h0) begin
            $display("FAIL reset_bc b_busy=%b b_bcd=%h c_bcd=%h exp 0", b_busy, b_bcd, c_bcd);
            n_fail++;
        end
`ifdef BCD_BLANK_EN
        n_tests++;
        if (a_blank !== 3'b111 || b_blank !== 5'b11111) begin
            $display("FAIL reset_blank a=%b b=%b exp 111/11111", a_blank, b_blank);
            n_fail++;
        end
`endif
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] vals [4];
        int lat;
        vals = '{8'd0, 8'd1, 8'd128, 8'd255};
        foreach (vals[k]) begin
            run_a(vals[k], lat);
            n_tests++;
            if (lat !== 9) begin
                $display("FAIL dir_lat v=%0d got %0d exp 9", vals[k], lat);
                n_fail++;
            end
            n_tests++;
            if (a_bcd !== ref_bcd(vals[k], 3) || a_ovf !== 1'b0 || a_busy !== 1'b0) begin
                $display("FAIL dir_bcd v=%0d got %h ovf=%b busy=%b exp %h 0 0",
                         vals[k], a_bcd, a_ovf, a_busy, ref_bcd(vals[k], 3));
                n_fail++;
            end
            @(negedge clk);
            n_tests++;
            if (a_done !== 1'b0 || a_bcd !== ref_bcd(vals[k], 3)) begin
                $display("FAIL dir_pulse v=%0d done=%b bcd=%h exp 0 %h",
                         vals[k], a_done, a_bcd, ref_bcd(vals[k], 3));
                n_fail++;
            end
        end
    endtask

    task automatic test_random();
        int lat;
        int unsigned v;
        for (int k = 0; k < 20; k++) begin
            v = $urandom_range(0, 255);
            run_a(8'(v), lat);
            n_tests++;
            if (lat !== 9 || a_bcd !== ref_bcd(v, 3) || a_ovf !== ref_ovf(v, 3)) begin
                $display("FAIL rand_a v=%0d lat=%0d bcd=%h ovf=%b exp 9 %h %b",
                         v, lat, a_bcd, a_ovf, ref_bcd(v, 3), ref_ovf(v, 3));
                n_fail++;
            end
`ifdef BCD_BLANK_EN
            n_tests++;
            if (a_blank !== ref_blank(v, 3)) begin
                $display("FAIL rand_a_blank v=%0d got %b exp %b", v, a_blank, ref_blank(v, 3));
                n_fail++;
            end
`endif
        end
        for (int k = 0; k < 10; k++) begin
            v = $urandom_range(0, 1023);
            if (k < 3) v = $urandom_range(1000, 1023);
            run_c(10'(v), lat);
            n_tests++;
            if (lat !== 11 || c_bcd !== ref_bcd(v, 3) || c_ovf !== ref_ovf(v, 3)) begin
                $display("FAIL rand_c v=%0d lat=%0d bcd=%h ovf=%b exp 11 %h %b",
                         v, lat, c_bcd, c_ovf, ref_bcd(v, 3), ref_ovf(v, 3));
                n_fail++;
            end
        end
        for (int k = 0; k < 8; k++) begin
            v = $urandom_range(0, 65535);
            run_b(16'(v), lat);
            n_tests++;
            if (lat !== 17 || b_bcd !== ref_bcd(v, 5) || b_ovf !== 1'b0) begin
                $display("FAIL rand_b v=%0d lat=%0d bcd=%h ovf=%b exp 17 %h 0",
                         v, lat, b_bcd, b_ovf, ref_bcd(v, 5));
                n_fail++;
            end
        end
    endtask

    task automatic test_start_ignored();
        int ndone, done_lat;
        logic [11:0] got;
        ndone = 0; done_lat = -1; got = '0;
        @(negedge clk);
        a_bin = 8'd200; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_bin = 8'd7;
        for (int lat = 1; lat <= 25; lat++) begin
            @(negedge clk);
            if (lat == 3) a_start = 1'b1;
            if (lat == 4) a_start = 1'b0;
            if (a_done) begin
                ndone++; done_lat = lat; got = a_bcd;
            end
        end
        n_tests++;
        if (ndone !== 1 || done_lat !== 9 || got !== 12'h200) begin
            $display("FAIL busy_start dones=%0d at=%0d bcd=%h exp 1 9 200", ndone, done_lat, got);
            n_fail++;
        end
    endtask

    task automatic test_reset_abort();
        int ndone, lat;
        @(negedge clk);
        a_bin = 8'd99; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_tests++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_bcd !== 12'h000 || a_ovf !== 1'b0) begin
            $display("FAIL abort_state busy=%b done=%b bcd=%h ovf=%b exp 0 0 000 0",
                     a_busy, a_done, a_bcd, a_ovf);
            n_fail++;
        end
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (a_done) ndone++;
        end
        n_tests++;
        if (ndone !== 0 || a_bcd !== 12'h000) begin
            $display("FAIL abort_nodone dones=%0d bcd=%h exp 0 000", ndone, a_bcd);
            n_fail++;
        end
        run_a(8'd42, lat);
        n_tests++;
        if (lat !== 9 || a_bcd !== 12'h042) begin
            $display("FAIL abort_next lat=%0d bcd=%h exp 9 042", lat, a_bcd);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        a_bin = 8'd64; a_start = 1'b1;
        cyc = 0;
        while (!a_done && cyc < 40) begin @(negedge clk); cyc++; end
        n_tests++;
        if (cyc !== 10 || a_bcd !== 12'h064) begin
            $display("FAIL b2b_first cyc=%0d bcd=%h exp 10 064", cyc, a_bcd);
            n_fail++;
        end
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            do begin @(negedge clk); cyc++; end while (!a_done && cyc < 40);
            n_tests++;
            if (cyc !== 10 || a_bcd !== 12'h064) begin
                $display("FAIL b2b_period k=%0d cyc=%0d bcd=%h exp 10 064", k, cyc, a_bcd);
                n_fail++;
            end
        end
        a_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wide_params();
        int lat;
        run_c(10'd1023, lat);
        n_tests++;
        if (lat !== 11 || c_bcd !== 12'h023 || c_ovf !== 1'b1) begin
            $display("FAIL c_1023 lat=%0d bcd=%h ovf=%b exp 11 023 1", lat, c_bcd, c_ovf);
            n_fail++;
        end
        run_c(10'd999, lat);
        n_tests++;
        if (c_bcd !== 12'h999 || c_ovf !== 1'b0) begin
            $display("FAIL c_999 bcd=%h ovf=%b exp 999 0", c_bcd, c_ovf);
            n_fail++;
        end
        run_b(16'd65535, lat);
        n_tests++;
        if (lat !== 17 || b_bcd !== 20'h65535 || b_ovf !== 1'b0) begin
            $display("FAIL b_65535 lat=%0d bcd=%h ovf=%b exp 17 65535 0", lat, b_bcd, b_ovf);
            n_fail++;
        end
        run_b(16'd7, lat);
        n_tests++;
        if (b_bcd !== 20'h00007) begin
            $display("FAIL b_7 bcd=%h exp 00007", b_bcd);
            n_fail++;
        end
`ifdef BCD_BLANK_EN
        n_tests++;
        if (b_blank !== 5'b00001) begin
            $display("FAIL b_7_blank got %b exp 00001", b_blank);
            n_fail++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_wide_params();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1);
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, with a start/done handshake.
- Successor to the fixed 8-bit-to-12-bit combinational converter; generalised to any binary width and digit count.
- Adds an overflow flag when DIGITS is too small for the value.
- Sits between datapath counters/registers and the HEX display drivers.

Parameters:
- BIN_W, 8, width of binary input; also the conversion length in shift cycles.
- DIGITS, 3, number of BCD output digits (4 bits each).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- start  input  1  request conversion of bin_in; sampled only when idle.
- bin_in  input  BIN_W  binary value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out/overflow update.
- bcd_out  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0]; held until next done.
- overflow  output  1  set with done if value > 10^DIGITS-1; held with bcd_out.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, shift counter=0. Applies mid-conversion too: the conversion is aborted and no done is produced.
- States:
  - IDLE -> SHIFT on start==1.
  - SHIFT -> SHIFT while count != 0.
  - SHIFT -> DONE when the last shift completes.
  - DONE -> IDLE, or DONE -> SHIFT if start==1 in DONE (back-to-back conversions).
- Accept edge (start==1 in IDLE or DONE):
  - load bin register = bin_in, BCD register = 0, count = BIN_W, sticky ovf = 0.
  - busy=1 from the next cycle.
- Each SHIFT cycle:
  - Every digit >= 5 is first adjusted by +3 (mod 16 within 4 bits).
  - Then {BCD, bin} shifts left one bit, count decrements.
  - If the bit shifted out of the top digit is 1, sticky ovf is set.
- Latency: done=1 in the cycle after exactly BIN_W+1 edges following the accept edge.
  - On that edge, bcd_out and overflow are registered and busy drops to 0.
- done is a single-cycle pulse in DONE; busy=0 in DONE.
- start while busy (SHIFT): ignored. No restart, no queueing, bin_in not resampled.
- Overflow result: bcd_out = value mod 10^DIGITS (low digits are exact), overflow=1.
- bin_in==0: bcd_out=0, overflow=0, same latency as any other value.
- Width rules: internal BCD register is 4*DIGITS bits; counter is clog2(BIN_W+1) bits. No other truncation.
- bcd_out/overflow never change except on a done edge or reset.

Optional Feature:
- Macro BCD_BLANK_EN.
- Defined:
  - Adds output blank_n [DIGITS-1:0], registered with bcd_out.
  - Bit i = 0 when digit i and all higher digits are zero, except digit 0 is never blanked.
  - Reset value all 1s.
  - Used for leading-zero suppression on HEX displays.
- Undefined: the port is absent and no blanking logic is built; all other behaviour is identical.

Decomposition:
- Shared package bcd_pkg:
  - state typedef {IDLE, SHIFT, DONE}.
  - constant DIGIT_W = 4.
  - constant ADJ_THRESH = 5.
  - constant ADJ_ADD = 3.
- One sub-module: bcd_add3, a combinational per-digit cell (4-bit in, 4-bit out, +3 if >= 5), instantiated DIGITS times via generate.

Test Plan:
- Default params; start with bin_in=8'd0, then 8'd1, 8'd128, 8'd255 in sequence.
  - bcd_out = 12'h000, 12'h001, 12'h128, 12'h255; overflow=0.
  - done exactly 9 edges after each accept.
- bin_in=8'd200 accepted; start=1 again at shift cycle 3 with bin_in=8'd7.
  - Second start ignored; single done with bcd_out=12'h200.
- Conversion of 8'd99 in flight; reset=0 for one edge at shift cycle 4.
  - busy=0, done never pulses, bcd_out=0.
  - A following start of 8'd42 yields 12'h042.
- start held high continuously with bin_in=8'd64.
  - done pulses every 10 cycles (accept in DONE); bcd_out=12'h064 each time.
- BIN_W=10, DIGITS=3, bin_in=10'd1023: bcd_out=12'h023, overflow=1. Then 10'd999: 12'h999, overflow=0.
- BIN_W=16, DIGITS=5, bin_in=16'd65535: bcd_out=20'h65535.
  - With BCD_BLANK_EN and bin_in=16'd7: blank_n=5'b00001.
